// File: rtl/gomoku_pkg.sv
// Shared Gomoku definitions: cell encoding, board geometry and the
// board_store FSM state set.
package gomoku_pkg;

  localparam int unsigned BOARD_DIM   = 16;
  localparam int unsigned BOARD_CELLS = BOARD_DIM * BOARD_DIM;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'd0;
  localparam cell_t CELL_BLACK = 2'd1;
  localparam cell_t CELL_WHITE = 2'd2;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    LOOKUP,
    JUDGE,
    COMMIT,
    REPORT
  } state_t;

endpackage

// File: rtl/board_ram.sv
// 256x2 dual-port board storage.
// Port A: synchronous read/write (FSM and wipe).
// Port B: synchronous read-only, write-first bypass against port A.
module board_ram
  import gomoku_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CELL_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [CELL_W-1:0] din_a,
  output logic [CELL_W-1:0] dout_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [CELL_W-1:0] dout_b
);

  logic [CELL_W-1:0] mem [BOARD_CELLS];

  // Storage array; contents are only ever cleared by the wipe sweep
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
  end

  // Registered read ports; port B forwards a same-cycle port A write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      dout_a <= mem[addr_a];
      dout_b <= (we_a && (addr_a == addr_b)) ? din_a : mem[addr_b];
    end
  end

endmodule

// File: rtl/board_store.sv
// Authoritative 16x16 Gomoku board with valid/ready move interface,
// legality judging, move count/turn tracking and a checker read port.
// Optional macro BOARD_STORE_TURN_CHECK_EN: reject moves whose colour
// differs from next_color.
module board_store
  import gomoku_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CELL_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  output logic              busy,
  input  logic              mv_valid,
  output logic              mv_ready,
  input  logic [ADDR_W-1:0] mv_addr,
  input  logic [CELL_W-1:0] mv_color,
  output logic              mv_done,
  output logic              mv_ok,
  output logic              check_start,
  output logic [ADDR_W-1:0] last_move,
  output logic [CELL_W-1:0] last_color,
  output logic [CELL_W-1:0] next_color,
  output logic [ADDR_W:0]   move_count,
  output logic              full,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CELL_W-1:0] rd_data
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] sweep;
  logic [ADDR_W-1:0] mv_addr_q;
  logic [CELL_W-1:0] mv_color_q;
  logic              result;
  logic              reject;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [CELL_W-1:0] ram_din;
  logic [CELL_W-1:0] ram_dout;

  board_ram #(
    .ADDR_W (ADDR_W),
    .CELL_W (CELL_W)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we_a   (ram_we),
    .addr_a (ram_addr),
    .din_a  (ram_din),
    .dout_a (ram_dout),
    .addr_b (rd_addr),
    .dout_b (rd_data)
  );

  assign full = (move_count == {1'b1, {ADDR_W{1'b0}}});

  // Legality of the captured move, judged against the cell read in LOOKUP
  always_comb begin
    reject = (ram_dout != CELL_EMPTY) || (mv_color_q == 2'd0) ||
             (mv_color_q == 2'd3) || full;
`ifdef BOARD_STORE_TURN_CHECK_EN
    if (mv_color_q != next_color) reject = 1'b1;
`endif
  end

  // State register plus move capture, result and board bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= CLEAR;
      sweep      <= '0;
      mv_addr_q  <= '0;
      mv_color_q <= '0;
      result     <= 1'b0;
      move_count <= '0;
      last_move  <= '0;
      last_color <= '0;
      next_color <= CELL_BLACK;
    end else begin
      state <= state_nx;
      case (state)
        CLEAR: sweep <= sweep + 1'b1;
        IDLE: begin
          if (clear) begin
            move_count <= '0;
            next_color <= CELL_BLACK;
            sweep      <= '0;
          end else if (mv_valid) begin
            mv_addr_q  <= mv_addr;
            mv_color_q <= mv_color;
          end
        end
        JUDGE: result <= !reject;
        COMMIT: begin
          move_count <= move_count + 1'b1;
          last_move  <= mv_addr_q;
          last_color <= mv_color_q;
          next_color <= (next_color == CELL_BLACK) ? CELL_WHITE : CELL_BLACK;
        end
        default: ;
      endcase
    end
  end

  // Next-state, handshake/result outputs and storage port A control
  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    mv_ready    = 1'b0;
    mv_done     = 1'b0;
    mv_ok       = 1'b0;
    check_start = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = mv_addr_q;
    ram_din     = mv_color_q;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = sweep;
        ram_din  = CELL_EMPTY;
        if (sweep == '1) state_nx = IDLE;
      end
      IDLE: begin
        mv_ready = !clear;
        if (clear)         state_nx = CLEAR;
        else if (mv_valid) state_nx = LOOKUP;
      end
      LOOKUP: state_nx = JUDGE;
      JUDGE:  state_nx = reject ? REPORT : COMMIT;
      COMMIT: begin
        ram_we   = 1'b1;
        state_nx = REPORT;
      end
      REPORT: begin
        mv_done     = 1'b1;
        mv_ok       = result;
        check_start = result;
        state_nx    = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: directed scenarios plus random moves
// and reads, compared against a board-array reference model.
module tb_board_store;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic       busy;
  logic       mv_valid = 1'b0;
  logic       mv_ready;
  logic [7:0] mv_addr = '0;
  logic [1:0] mv_color = '0;
  logic       mv_done;
  logic       mv_ok;
  logic       check_start;
  logic [7:0] last_move;
  logic [1:0] last_color;
  logic [1:0] next_color;
  logic [8:0] move_count;
  logic       full;
  logic [7:0] rd_addr = '0;
  logic [1:0] rd_data;

  board_store dut (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (clear),
    .busy        (busy),
    .mv_valid    (mv_valid),
    .mv_ready    (mv_ready),
    .mv_addr     (mv_addr),
    .mv_color    (mv_color),
    .mv_done     (mv_done),
    .mv_ok       (mv_ok),
    .check_start (check_start),
    .last_move   (last_move),
    .last_color  (last_color),
    .next_color  (next_color),
    .move_count  (move_count),
    .full        (full),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model
  logic [1:0] m_board [256];
  int         m_count;
  logic [1:0] m_next;
  logic [7:0] m_last;
  logic [1:0] m_last_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_wipe();
    for (int i = 0; i < 256; i++) m_board[i] = 2'd0;
    m_count = 0;
    m_next  = 2'd1;
  endtask

  function automatic bit model_legal(input logic [7:0] a, input logic [1:0] c);
    bit ok;
    ok = (m_board[a] == 2'd0) && (c == 2'd1 || c == 2'd2) && (m_count < 256);
`ifdef BOARD_STORE_TURN_CHECK_EN
    if (c != m_next) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic wait_wipe(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 256);
    chk({tag, "_ready"}, mv_ready, 1);
    model_wipe();
  endtask

  task automatic do_move(input logic [7:0] a, input logic [1:0] c);
    int  n = 0;
    int  lat;
    bit  legal;
    while (!mv_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("ready_before_move", mv_ready, 1);
    legal    = model_legal(a, c);
    mv_addr  = a;
    mv_color = c;
    mv_valid = 1'b1;
    @(negedge clk);
    mv_valid = 1'b0;
    lat = 1;
    while (!mv_done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (legal) begin
      m_board[a] = c;
      m_count++;
      m_last   = a;
      m_last_c = c;
      m_next   = (m_next == 2'd1) ? 2'd2 : 2'd1;
    end
    chk("done_latency", lat, legal ? 4 : 3);
    chk("mv_ok", mv_ok, legal);
    chk("check_start", check_start, legal);
    chk("last_move", last_move, m_last);
    chk("last_color", last_color, m_last_c);
    chk("move_count", move_count, m_count);
    chk("next_color", next_color, m_next);
    chk("full", full, (m_count == 256));
    @(negedge clk);
    chk("done_one_cycle", {mv_done, check_start}, 0);
  endtask

  task automatic do_read(input logic [7:0] a);
    rd_addr = a;
    @(negedge clk);
    chk("rd_data", rd_data, m_board[a]);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", busy, 1);
    chk("rst_ready", mv_ready, 0);
    chk("rst_done", mv_done, 0);
    chk("rst_ok", mv_ok, 0);
    chk("rst_cs", check_start, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_last", last_move, 0);
    chk("rst_lastc", last_color, 0);
    chk("rst_next", next_color, 1);
    chk("rst_count", move_count, 0);
    chk("rst_full", full, 0);
  endtask

  initial begin
    m_last   = '0;
    m_last_c = '0;
    model_wipe();

    // Reset state and first wipe
    repeat (3) @(negedge clk);
    check_reset_vals();
    resetn = 1'b1;
    wait_wipe("init");
    do_read(8'h37);

    // Directed moves
    do_move(8'h37, 2'd1);
    do_read(8'h37);
    do_move(8'h37, 2'd2);
    do_move(8'h40, 2'd3);
    do_move(8'h41, 2'd0);
    do_move(8'h38, 2'd1);
    do_read(8'h38);

    // Random moves in a small window to provoke collisions
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [7:0] a;
      logic [1:0] c;
      a = 8'(8'h30 + $urandom_range(0, 31));
      r = $urandom_range(0, 9);
      c = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? m_next : 2'($urandom_range(1, 2));
      do_move(a, c);
    end
    for (int i = 0; i < 20; i++) do_read(8'(8'h30 + $urandom_range(0, 31)));

    // clear wins over a simultaneous move request
    @(negedge clk);
    clear    = 1'b1;
    mv_valid = 1'b1;
    mv_addr  = 8'h50;
    mv_color = m_next;
    #1;
    chk("clear_blocks_ready", mv_ready, 0);
    @(negedge clk);
    clear    = 1'b0;
    mv_valid = 1'b0;
    chk("clear_no_done", mv_done, 0);
    wait_wipe("clear");
    chk("clear_count", move_count, 0);
    chk("clear_next", next_color, 1);
    do_read(8'h37);
    do_read(8'h50);

    // Fill the whole board, then one more move
    for (int i = 0; i < 256; i++) do_move(8'(i), m_next);
    chk("full_flag", full, 1);
    do_move(8'h00, m_next);
    for (int i = 0; i < 8; i++) do_read(8'($urandom_range(0, 255)));

    // Reset asserted during COMMIT
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_wipe("pre_rst");
    mv_addr  = 8'h22;
    mv_color = 2'd1;
    mv_valid = 1'b1;
    @(negedge clk);
    mv_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_wipe("post_rst");
    do_read(8'h22);
    do_read(8'h37);
    do_move(8'h22, 2'd1);
    do_read(8'h22);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/board_store.md
# board_store

Authoritative 16x16 Gomoku board. Accepts stone placements through a valid/ready move interface, rejects illegal moves, and tracks move count and turn. Serves 2-bit cell reads to the line checkers (horizontal, vertical, both diagonals) with 1-cycle registered latency. On each accepted move it pulses a start strobe and presents the move address as the checkers' pointer.

## Interface
- ADDR_W, 8, cell address {row[7:4], col[3:0]}
- CELL_W, 2, cell encoding width

- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- clear  in  1  request full-board wipe
- busy  out  1  high while a wipe is in progress
- mv_valid  in  1  move request
- mv_ready  out  1  move accepted this cycle when mv_valid is also high
- mv_addr  in  8  target cell
- mv_color  in  2  stone colour: 1 = BLACK, 2 = WHITE
- mv_done  out  1  one-cycle result pulse
- mv_ok  out  1  qualifies mv_done: 1 = placed, 0 = rejected
- check_start  out  1  one-cycle pulse on accept; drives the horizontal checker's active input
- last_move  out  8  address of last accepted move; checker pointer
- last_color  out  2  colour of last accepted move; checker chess input
- next_color  out  2  expected colour of the next move
- move_count  out  9  accepted moves since the last wipe, 0..256
- full  out  1  high when move_count == 256
- rd_addr  in  8  checker read address
- rd_data  out  2  cell content at the rd_addr sampled on the previous edge

## Operation
- States: CLEAR, IDLE, LOOKUP, JUDGE, COMMIT, REPORT.
- CLEAR
  - Writes EMPTY (0) to cells 0..255, one per cycle, using an 8-bit sweep counter.
  - busy = 1 throughout; enters IDLE after writing cell 255.
- IDLE
  - mv_ready = (state == IDLE) && !clear.
  - clear has priority: clear → CLEAR; move_count := 0, next_color := BLACK, sweep counter := 0.
  - Otherwise a handshake captures mv_addr and mv_color and moves to LOOKUP.
- LOOKUP: storage port A reads the captured address.
- JUDGE: reject if any of the following holds, else go to COMMIT:
  - the cell is not EMPTY;
  - colour is 0 or 3;
  - full = 1;
  - turn mismatch (only when the Configuration macro is defined).
  - On reject, go to REPORT with result = 0.
- COMMIT
  - Writes the colour to the cell and increments move_count.
  - Updates last_move and last_color.
  - Toggles next_color (BLACK ↔ WHITE).
  - Goes to REPORT with result = 1.
- REPORT: mv_done = 1, mv_ok = result, check_start = result; then IDLE.
- clear is ignored outside IDLE.
- Read port B: independent of the FSM; rd_data is registered from rd_addr every cycle.
  - Write-first: a COMMIT or CLEAR write to rd_addr is visible in rd_data on the following cycle.
- Reset (asserted at any time, including mid-COMMIT): state := CLEAR and a full wipe follows.
  - Reset values: busy 1, mv_ready 0, mv_done 0, mv_ok 0, check_start 0, rd_data 0, last_move 0, last_color 0, next_color BLACK (1), move_count 0, full 0, sweep counter 0.
  - Storage contents are not reset directly; the wipe clears them.

## Timing
- Wipe takes 256 cycles; mv_ready first rises in the cycle after cell 255 is written.
- Handshake in cycle N:
  - rejected move: mv_done in cycle N+3;
  - accepted move: mv_done in cycle N+4.
- mv_done and check_start are high for exactly one cycle.
- A new move cannot be accepted before the cycle after REPORT.
- last_move, last_color and move_count are stable in the REPORT cycle, before check_start is sampled.
- Read latency is 1 cycle: address on edge k, data valid after edge k+1.

## Configuration
- BOARD_STORE_TURN_CHECK_EN defined:
  - a move whose mv_color ≠ next_color is rejected;
  - next_color starts at BLACK after every wipe.
- Undefined:
  - colour order is not enforced; any colour of 1 or 2 is accepted;
  - next_color still toggles but is advisory only.

## Structure
- Shared package gomoku_pkg:
  - cell typedef and constants CELL_EMPTY = 0, CELL_BLACK = 1, CELL_WHITE = 2;
  - BOARD_DIM = 16, BOARD_CELLS = 256;
  - the FSM state enum.
- Sub-module board_ram: 256x2 dual-port storage.
  - Port A: synchronous read/write, used by the FSM and the wipe.
  - Port B: synchronous read-only, write-first bypass against port A.

## Test plan
- Release reset → busy = 1 for 256 cycles, then mv_ready = 1; rd_addr = 0x37 → rd_data = 0 one cycle later.
- BLACK at 0x37 → mv_done & mv_ok in handshake+4, check_start pulse, last_move = 0x37, last_color = 1, move_count = 1, rd_data(0x37) = 1.
- WHITE at occupied 0x37 → mv_done with mv_ok = 0 in handshake+3, no check_start, move_count stays 1; colour 3 at 0x40 → rejected.
- After BLACK, BLACK at 0x38 → rejected with the macro defined, accepted without it.
- clear and mv_valid in the same IDLE cycle → no move accepted, busy for 256 cycles, move_count = 0, next_color = 1, rd_data(0x37) = 0.
- Fill 256 cells, then one more move → full = 1, move rejected; assert resetn low during COMMIT → all outputs take reset values immediately and a wipe follows.
